// File: rtl/bimodal_predictor_pkg.sv
// Shared types and saturating-counter helpers for the bimodal predictor and
// later direction predictors (tournament, gshare).
package bimodal_predictor_pkg;

    localparam int unsigned MAX_COUNTER_WIDTH = 16;
    localparam int unsigned WIDE_WIDTH        = MAX_COUNTER_WIDTH + 1;

    typedef logic [MAX_COUNTER_WIDTH-1:0] count_t;
    typedef logic [WIDE_WIDTH-1:0]        wide_t;

    // Clamped next state: one extra bit of headroom, then limit to count_range-1.
    function automatic count_t saturate_step(input count_t count, input logic up,
                                             input int unsigned count_range);
        wide_t wide_s;
        wide_t top_s;
        count_t result_s;
        top_s = wide_t'(count_range - 32'd1);
        if (up) begin
            wide_s = {1'b0, count} + wide_t'(1'b1);
        end else if (count == count_t'(1'b0)) begin
            wide_s = wide_t'(1'b0);
        end else begin
            wide_s = {1'b0, count} - wide_t'(1'b1);
        end
        if (wide_s > top_s) begin
            result_s = count_t'(top_s);
        end else begin
            result_s = count_t'(wide_s);
        end
        return result_s;
    endfunction

    function automatic logic is_taken(input count_t count, input int unsigned count_range);
        return (count >= count_t'(count_range / 32'd2));
    endfunction

endpackage

// File: rtl/bimodal_predictor_entry.sv
// One saturating counter of the prediction table; exposes its next state so
// the top level can bypass a same-cycle update into a prediction.
module bimodal_predictor_entry
    import bimodal_predictor_pkg::*;
#(
    parameter int unsigned COUNTER_RANGE = 4,
    parameter int unsigned RESET_VALUE   = 1,
    parameter int unsigned COUNTER_WIDTH = $clog2(COUNTER_RANGE)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     up,
    output logic [COUNTER_WIDTH-1:0] next_count
);

    logic [COUNTER_WIDTH-1:0] count_r;

    // Next-state: step only when this entry is the update target.
    always_comb begin
        next_count = count_r;
        if (enable) begin
            next_count = COUNTER_WIDTH'(saturate_step(count_t'(count_r), up, COUNTER_RANGE));
        end else begin
            next_count = count_r;
        end
    end

    // Counter state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= COUNTER_WIDTH'(RESET_VALUE);
        end else begin
            count_r <= next_count;
        end
    end

endmodule

// File: rtl/bimodal_predictor.sv
// Bimodal branch-direction predictor: a flop table of saturating counters
// with one-cycle registered prediction and same-cycle update bypass.
module bimodal_predictor
    import bimodal_predictor_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH   = 4,
    parameter int unsigned COUNTER_RANGE = 4,
    parameter int unsigned RESET_VALUE   = 1,
    localparam int unsigned ENTRIES       = 2 ** INDEX_WIDTH,
    localparam int unsigned COUNTER_WIDTH = $clog2(COUNTER_RANGE)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     predict_valid,
    input  logic [INDEX_WIDTH-1:0]   predict_index,
    output logic                     prediction_valid,
    output logic                     prediction_taken,
    output logic [COUNTER_WIDTH-1:0] prediction_count,
    input  logic                     update_valid,
    input  logic [INDEX_WIDTH-1:0]   update_index,
    input  logic                     update_taken
);

    if ((COUNTER_RANGE < 2) || (RESET_VALUE >= COUNTER_RANGE) ||
        (COUNTER_WIDTH > MAX_COUNTER_WIDTH)) begin : g_bad_params
        $fatal(1, "bimodal_predictor: illegal COUNTER_RANGE/RESET_VALUE");
    end

    logic [ENTRIES-1:0]       update_en_s;
    logic [COUNTER_WIDTH-1:0] next_count_s [ENTRIES];
    logic [COUNTER_WIDTH-1:0] read_count_s;

    // One-hot decode of the update target.
    always_comb begin
        update_en_s = ENTRIES'(1'b0);
        if (update_valid) begin
            update_en_s[update_index] = 1'b1;
        end else begin
            update_en_s = ENTRIES'(1'b0);
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        bimodal_predictor_entry #(
            .COUNTER_RANGE (COUNTER_RANGE),
            .RESET_VALUE   (RESET_VALUE),
            .COUNTER_WIDTH (COUNTER_WIDTH)
        ) u_entry (
            .clock      (clock),
            .reset      (reset),
            .enable     (update_en_s[i]),
            .up         (update_taken),
            .next_count (next_count_s[i])
        );
    end

    // Read from next-state so a same-index update is visible immediately.
    always_comb begin
        read_count_s = next_count_s[predict_index];
    end

    // Output register; taken/count hold while no request is made.
    always_ff @(posedge clock) begin
        if (reset) begin
            prediction_valid <= 1'b0;
            prediction_taken <= 1'b0;
            prediction_count <= COUNTER_WIDTH'(1'b0);
        end else if (predict_valid) begin
            prediction_valid <= 1'b1;
            prediction_taken <= is_taken(count_t'(read_count_s), COUNTER_RANGE);
            prediction_count <= read_count_s;
        end else begin
            prediction_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bimodal_predictor.sv
// Directed and randomized checks of bimodal_predictor against an array model.
module tb_bimodal_predictor;

    localparam int IW  = 4;
    localparam int RNG = 4;
    localparam int RV  = 1;
    localparam int N   = 2 ** IW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          predict_valid = 1'b0;
    logic [IW-1:0] predict_index = '0;
    logic          prediction_valid;
    logic          prediction_taken;
    logic [1:0]    prediction_count;
    logic          update_valid = 1'b0;
    logic [IW-1:0] update_index = '0;
    logic          update_taken = 1'b0;

    int total = 0;
    int bad   = 0;

    int mdl [N];
    int exp_valid = 0;
    int exp_taken = 0;
    int exp_count = 0;
    int sat_hi = 0;
    int sat_lo = 0;
    int collide = 0;
    int idle = 0;

    bimodal_predictor #(.INDEX_WIDTH(IW), .COUNTER_RANGE(RNG), .RESET_VALUE(RV)) dut (
        .clock            (clock),
        .reset            (reset),
        .predict_valid    (predict_valid),
        .predict_index    (predict_index),
        .prediction_valid (prediction_valid),
        .prediction_taken (prediction_taken),
        .prediction_count (prediction_count),
        .update_valid     (update_valid),
        .update_index     (update_index),
        .update_taken     (update_taken)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic cycle(input logic rst, input logic pv, input int pi,
                         input logic uv, input int ui, input logic ut);
        reset = rst;
        predict_valid = pv;
        predict_index = IW'(pi);
        update_valid = uv;
        update_index = IW'(ui);
        update_taken = ut;
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < N; i++) mdl[i] = RV;
            exp_valid = 0;
            exp_taken = 0;
            exp_count = 0;
        end else begin
            if (uv) begin
                if (ut && mdl[ui] == RNG - 1) sat_hi++;
                if (!ut && mdl[ui] == 0) sat_lo++;
                if (ut) mdl[ui] = (mdl[ui] + 1 > RNG - 1) ? RNG - 1 : mdl[ui] + 1;
                else    mdl[ui] = (mdl[ui] - 1 < 0) ? 0 : mdl[ui] - 1;
            end
            if (pv) begin
                if (uv && ui == pi) collide++;
                exp_valid = 1;
                exp_count = mdl[pi];
                exp_taken = (mdl[pi] >= RNG / 2) ? 1 : 0;
            end else begin
                idle++;
                exp_valid = 0;
            end
        end
        #1;
        chk("valid", 32'(prediction_valid), 32'(exp_valid));
        chk("taken", 32'(prediction_taken), 32'(exp_taken));
        chk("count", 32'(prediction_count), 32'(exp_count));
    endtask

    initial begin
        int up_seq [4];
        int dn_seq [4];
        int bias;
        int span;
        logic pv, uv, ut, rs;
        up_seq = '{2, 3, 3, 3};
        dn_seq = '{2, 1, 0, 0};

        // Reset state
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        chk("reset_valid", 32'(prediction_valid), 32'd0);
        chk("reset_count", 32'(prediction_count), 32'd0);

        // Back-to-back reads of every entry after reset
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 1'b1, i, 1'b0, 0, 1'b0);
            chk("init_valid", 32'(prediction_valid), 32'd1);
            chk("init_count", 32'(prediction_count), 32'd1);
            chk("init_taken", 32'(prediction_taken), 32'd0);
        end
        cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        chk("idle_valid", 32'(prediction_valid), 32'd0);
        chk("idle_hold_count", 32'(prediction_count), 32'd1);

        // Saturate entry 3 upward then downward
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 3, 1'b1, 3, 1'b1);
            chk("up_count", 32'(prediction_count), 32'(up_seq[i]));
            chk("up_taken", 32'(prediction_taken), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 3, 1'b1, 3, 1'b0);
            chk("dn_count", 32'(prediction_count), 32'(dn_seq[i]));
            chk("dn_taken", 32'(prediction_taken), 32'(dn_seq[i] >= 2 ? 1 : 0));
        end

        // Same-cycle bypass and cross-index independence
        cycle(1'b0, 1'b1, 5, 1'b1, 5, 1'b1);
        chk("bypass_count", 32'(prediction_count), 32'd2);
        chk("bypass_taken", 32'(prediction_taken), 32'd1);
        cycle(1'b0, 1'b1, 8, 1'b1, 7, 1'b1);
        chk("other_count", 32'(prediction_count), 32'd1);

        // Train entries 0..3 to the top, then reset mid-operation
        for (int e = 0; e < 4; e++)
            for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 0, 1'b1, e, 1'b1);
        cycle(1'b0, 1'b1, 2, 1'b0, 0, 1'b0);
        chk("trained_count", 32'(prediction_count), 32'd3);
        cycle(1'b1, 1'b1, 0, 1'b1, 0, 1'b1);
        chk("midreset_valid", 32'(prediction_valid), 32'd0);
        chk("midreset_count", 32'(prediction_count), 32'd0);
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 1'b1, i, 1'b0, 0, 1'b0);
            chk("post_reset_count", 32'(prediction_count), 32'd1);
        end

        // Randomized traffic in phases of varying direction bias and index spread
        for (int ph = 0; ph < 10; ph++) begin
            bias = $urandom_range(0, 100);
            span = (ph % 3 == 0) ? 1 : N - 1;
            for (int c = 0; c < 1000; c++) begin
                rs = ($urandom_range(0, 999) == 0);
                pv = ($urandom_range(0, 99) < 75);
                uv = ($urandom_range(0, 99) < 70);
                ut = ($urandom_range(0, 99) < bias);
                cycle(rs, pv, $urandom_range(0, span), uv, $urandom_range(0, span), ut);
            end
        end
        chk("cov_sat_hi", 32'(sat_hi > 0), 32'd1);
        chk("cov_sat_lo", 32'(sat_lo > 0), 32'd1);
        chk("cov_collide", 32'(collide > 0), 32'd1);
        chk("cov_idle", 32'(idle > 0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
